// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory master.
package lsu_pkg;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_FILL = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_DONE
    } state_e;

    localparam int MAX_BURST     = 16;
    localparam int MEM_DEPTH_DEF = 1024;
    localparam int IDX_W         = $clog2(MAX_BURST + 1);

    // Zero-length requests still move one word; oversized ones saturate.
    function automatic logic [IDX_W-1:0] eff_len(input logic [31:0] len);
        if (len == 32'd0)
            return IDX_W'(1);
        else if (len > 32'(MAX_BURST))
            return IDX_W'(MAX_BURST);
        else
            return IDX_W'(len);
    endfunction

endpackage

// File: rtl/lsu_resp_fifo.sv
// Two-entry load-response buffer; head is valid whenever count_o is non-zero.
// A same-cycle push and pop leave the count unchanged.
module lsu_resp_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    input  logic        pop_i,
    output logic [31:0] head_o,
    output logic [1:0]  count_o
);

    logic [31:0] mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i)
                wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)
                rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk) begin
        if (push_i)
            mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/lsu_mem_master.sv
// Burst load/fill initiator for the synchronous data memory; first load word 3 cycles after accept.
// Reads stall when two words are buffered or in flight. LSU_BOUNDS_CHECK_EN enables range rejection.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LEN_W-1:0]    req_len,
    input  logic [31:0]         req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic signed [31:0]  resp_data,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wrData,
    output logic                mem_wrMem,
    output logic                mem_rdMem,
    input  logic signed [31:0]  mem_rdData
);

    localparam int AW1 = ADDR_W + 1;

    if (MEM_DEPTH < 1 || LEN_W > 32) begin : g_bad_cfg
        $error("lsu_mem_master: MEM_DEPTH must be positive and LEN_W at most 32");
    end

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [IDX_W-1:0]  len_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       wdata_q;
    logic              inflight_q;

    logic [IDX_W-1:0]  req_len_eff;
    logic              req_bad;
    logic              accept;
    logic              pop;
    logic              issue;
    logic              load_last;
    logic [2:0]        occ;
    logic [1:0]        fifo_cnt;
    logic [31:0]       fifo_head;

    assign req_len_eff = eff_len(32'(req_len));
    assign req_ready   = (state_q == S_IDLE);
    assign accept      = req_ready && req_valid;

    assign resp_valid = (fifo_cnt != 2'd0);
    assign resp_data  = resp_valid ? $signed(fifo_head) : 32'sd0;
    assign pop        = resp_valid && resp_ready;

    // Words in the buffer plus the read still in the memory pipeline, net of this cycle's pop.
    assign occ   = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue = (state_q == S_LOAD) && (idx_q < len_q) && (occ < 3'd2);

    assign load_last = (state_q == S_LOAD) && (idx_q == len_q) && !inflight_q
                       && (fifo_cnt == {1'b0, pop});

    assign mem_wrMem  = (state_q == S_FILL);
    assign mem_rdMem  = issue;
    assign mem_addr   = (mem_wrMem || mem_rdMem) ? base_q + ADDR_W'(idx_q) : '0;
    assign mem_wrData = mem_wrMem ? wdata_q : '0;
    assign done       = (state_q == S_DONE);

`ifdef LSU_BOUNDS_CHECK_EN
    logic [AW1-1:0] last_addr;
    logic           err_q;

    // One extra bit catches wrap past the top of the address space.
    assign last_addr = {1'b0, req_addr} + AW1'(req_len_eff) - AW1'(1);
    assign req_bad   = (last_addr >= AW1'(MEM_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= accept && req_bad;
    end

    assign err = err_q;
`else
    assign req_bad = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        base_q  <= req_addr;
                        len_q   <= req_len_eff;
                        wdata_q <= req_wdata;
                        idx_q   <= '0;
                        if (req_bad)
                            state_q <= S_DONE;
                        else if (req_op == OP_FILL)
                            state_q <= S_FILL;
                        else
                            state_q <= S_LOAD;
                    end
                end
                S_FILL: begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == len_q - IDX_W'(1))
                        state_q <= S_DONE;
                end
                S_LOAD: begin
                    if (issue)
                        idx_q <= idx_q + IDX_W'(1);
                    if (load_last)
                        state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    lsu_resp_fifo u_resp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (mem_rdData),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_cnt)
    );

endmodule

// File: tb/tb_lsu_mem_master.sv
// Table-driven bench for lsu_mem_master with a behavioural data memory and a response scoreboard.
module tb_lsu_mem_master;

    localparam int DEPTH = 1024;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic               req_op;
    logic [31:0]        req_addr;
    logic [4:0]         req_len;
    logic [31:0]        req_wdata;
    logic               resp_valid;
    logic               resp_ready;
    logic signed [31:0] resp_data;
    logic               done;
    logic               err;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wrData;
    logic               mem_wrMem;
    logic               mem_rdMem;
    logic signed [31:0] mem_rdData;

    logic               preload;
    logic [31:0]        mem [DEPTH];
    int                 ref_mem [DEPTH];
    int                 exp_q [$];
    int                 errors;
    int                 checks;

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [4:0]  len;
        logic [31:0] wdata;
        int          exp_n;
        int          exp_err;
        int          exp_done;
        int          exp_first;
        int          stall;
    } vec_t;

    vec_t vecs [10];

    lsu_mem_master dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_wrData (mem_wrData),
        .mem_wrMem  (mem_wrMem),
        .mem_rdMem  (mem_rdMem),
        .mem_rdData (mem_rdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory aliases modulo DEPTH, read data registered on the sampling edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= 32'((k + 1) * 10);
            mem_rdData <= '0;
        end else begin
            if (mem_wrMem)
                mem[mem_addr[9:0]] <= mem_wrData;
            if (mem_rdMem)
                mem_rdData <= mem[mem_addr[9:0]];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int          eff;
        int          n_wr;
        int          n_rd;
        int          n_pop;
        int          done_cyc;
        int          first_cyc;
        int          err_seen;
        int          max_occ;
        int          idle_bad;
        int          both_hi;
        int          exp_d;
        logic [31:0] a;

        eff = (v.len == 5'd0) ? 1 : ((v.len > 5'd16) ? 16 : int'(v.len));
        @(negedge clk);
        #1;
        check($sformatf("v%0d req_ready before", id), int'(req_ready), 1);
        req_valid  = 1'b1;
        req_op     = v.op;
        req_addr   = v.addr;
        req_len    = v.len;
        req_wdata  = v.wdata;
        resp_ready = 1'b0;
        if (v.exp_err == 0) begin
            for (int k = 0; k < eff; k++) begin
                a = v.addr + 32'(k);
                if (v.op)
                    ref_mem[a[9:0]] = int'(v.wdata);
                else
                    exp_q.push_back(ref_mem[a[9:0]]);
            end
        end

        n_wr = 0; n_rd = 0; n_pop = 0; done_cyc = 0; first_cyc = 0;
        err_seen = 0; max_occ = 0; idle_bad = 0; both_hi = 0;
        for (int c = 1; c <= 80 && done_cyc == 0; c++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            resp_ready = (c > v.stall);
            #1;
            if (mem_wrMem && mem_rdMem)
                both_hi++;
            if (mem_wrMem) begin
                check($sformatf("v%0d wr addr", id), int'(mem_addr), int'(v.addr + 32'(n_wr)));
                check($sformatf("v%0d wr data", id), int'(mem_wrData), int'(v.wdata));
                n_wr++;
            end
            if (mem_rdMem) begin
                check($sformatf("v%0d rd addr", id), int'(mem_addr), int'(v.addr + 32'(n_rd)));
                n_rd++;
            end
            if (resp_valid && first_cyc == 0)
                first_cyc = c;
            if (!resp_valid && resp_data != 0)
                idle_bad++;
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("v%0d unexpected word", id), 1, 0);
                end else begin
                    exp_d = exp_q.pop_front();
                    check($sformatf("v%0d resp_data", id), int'(resp_data), exp_d);
                end
                n_pop++;
            end
            if (n_rd - n_pop > max_occ)
                max_occ = n_rd - n_pop;
            if (done) begin
                done_cyc = c;
                err_seen = int'(err);
            end
        end

        check($sformatf("v%0d done seen", id), int'(done_cyc != 0), 1);
        check($sformatf("v%0d words accessed", id), v.op ? n_wr : n_rd, v.exp_n);
        check($sformatf("v%0d other strobe", id), v.op ? n_rd : n_wr, 0);
        check($sformatf("v%0d strobes exclusive", id), both_hi, 0);
        check($sformatf("v%0d err", id), err_seen, v.exp_err);
        check($sformatf("v%0d done cycle", id), done_cyc, v.exp_done);
        if (v.op == 1'b0 && v.exp_err == 0)
            check($sformatf("v%0d first resp cycle", id), first_cyc, v.exp_first);
        check($sformatf("v%0d in flight <= 2", id), int'(max_occ <= 2), 1);
        check($sformatf("v%0d resp_data zero when idle", id), idle_bad, 0);
        check($sformatf("v%0d scoreboard drained", id), exp_q.size(), 0);
        exp_q.delete();

        @(negedge clk);
        #1;
        check($sformatf("v%0d done one cycle", id), int'(done), 0);
        check($sformatf("v%0d req_ready after", id), int'(req_ready), 1);
    endtask

    initial begin
        int no_done;

        errors = 0;
        checks = 0;
        for (int k = 0; k < DEPTH; k++)
            ref_mem[k] = (k + 1) * 10;

        vecs[0] = '{op:1'b1, addr:32'd5,   len:5'd3,  wdata:32'hFFFF_FFF9, exp_n:3,  exp_err:0, exp_done:4,  exp_first:0, stall:0};
        vecs[1] = '{op:1'b0, addr:32'd0,   len:5'd4,  wdata:32'd0,         exp_n:4,  exp_err:0, exp_done:7,  exp_first:3, stall:0};
        vecs[2] = '{op:1'b0, addr:32'd5,   len:5'd3,  wdata:32'd0,         exp_n:3,  exp_err:0, exp_done:6,  exp_first:3, stall:0};
        vecs[3] = '{op:1'b0, addr:32'd0,   len:5'd4,  wdata:32'd0,         exp_n:4,  exp_err:0, exp_done:10, exp_first:3, stall:5};
        vecs[4] = '{op:1'b1, addr:32'd100, len:5'd0,  wdata:32'd55,        exp_n:1,  exp_err:0, exp_done:2,  exp_first:0, stall:0};
        vecs[5] = '{op:1'b0, addr:32'd100, len:5'd0,  wdata:32'd0,         exp_n:1,  exp_err:0, exp_done:4,  exp_first:3, stall:0};
        vecs[6] = '{op:1'b0, addr:32'd0,   len:5'd31, wdata:32'd0,         exp_n:16, exp_err:0, exp_done:19, exp_first:3, stall:0};
        vecs[7] = '{op:1'b1, addr:32'd200, len:5'd31, wdata:32'h1234_5678, exp_n:16, exp_err:0, exp_done:17, exp_first:0, stall:0};
        vecs[8] = '{op:1'b0, addr:32'd200, len:5'd16, wdata:32'd0,         exp_n:16, exp_err:0, exp_done:19, exp_first:3, stall:0};
`ifdef LSU_BOUNDS_CHECK_EN
        vecs[9] = '{op:1'b0, addr:32'd1020, len:5'd8, wdata:32'd0,         exp_n:0,  exp_err:1, exp_done:1,  exp_first:0, stall:0};
`else
        vecs[9] = '{op:1'b0, addr:32'd1020, len:5'd8, wdata:32'd0,         exp_n:8,  exp_err:0, exp_done:11, exp_first:3, stall:0};
`endif

        preload    = 1'b1;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        preload = 1'b0;
        #1;
        check("reset req_ready", int'(req_ready), 1);
        check("reset resp_valid", int'(resp_valid), 0);
        check("reset resp_data", int'(resp_data), 0);
        check("reset done", int'(done), 0);
        check("reset err", int'(err), 0);
        check("reset mem strobes", int'({mem_wrMem, mem_rdMem}), 0);
        check("reset mem_addr", int'(mem_addr), 0);
        check("reset mem_wrData", int'(mem_wrData), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_vec(i, vecs[i]);

        // Reset asserted in the middle of a load after two words have been consumed.
        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = 1'b0;
        req_addr   = 32'd0;
        req_len    = 5'd8;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("pre-reset issuing", int'(mem_rdMem), 1);
        check("pre-reset resp_valid", int'(resp_valid), 1);
        rst = 1'b1;
        #1;
        check("mid reset rdMem", int'(mem_rdMem), 0);
        check("mid reset wrMem", int'(mem_wrMem), 0);
        check("mid reset mem_addr", int'(mem_addr), 0);
        check("mid reset resp_valid", int'(resp_valid), 0);
        check("mid reset resp_data", int'(resp_data), 0);
        check("mid reset req_ready", int'(req_ready), 1);
        check("mid reset done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        no_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (done || resp_valid || mem_rdMem || mem_wrMem)
                no_done++;
        end
        check("post reset quiet", no_done, 0);

        run_vec(10, vecs[1]);
        run_vec(11, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
